// File: rtl/fpu_defs.sv
// Shared FPU definitions: widths, command encodings and the request/tag types
// used by the FPU front-end arbiter.
package fpu_defs;

  localparam int C_OP        = 32;
  localparam int C_RM        = 3;
  localparam int C_CMD       = 4;
  localparam int C_FPU_FLAGS = 6;
  localparam int C_ID_W      = 3;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD = 4'h3;

  // Flag vector order is {OF,UF,Zero,IX,IV,Inf}
  localparam int C_FLAG_INF  = 0;
  localparam int C_FLAG_IV   = 1;
  localparam int C_FLAG_IX   = 2;
  localparam int C_FLAG_ZERO = 3;
  localparam int C_FLAG_UF   = 4;
  localparam int C_FLAG_OF   = 5;

  typedef struct packed {
    logic [C_OP-1:0]  op_a;
    logic [C_OP-1:0]  op_b;
    logic [C_RM-1:0]  rm;
    logic [C_CMD-1:0] op;
  } fpu_req_t;

  typedef struct packed {
    logic              valid;
    logic [C_ID_W-1:0] id;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_shared_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from pointer+1 upward with wrap, grants at most
// one requester per enabled cycle, and parks the pointer on the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI)
      ptr_q <= ID_W'(NUM_REQ - 1);
    else if (found)
      ptr_q <= idx;
  end

endmodule

// File: rtl/fpu_shared_arbiter.sv
// Shares one fixed-latency FPU among NUM_REQ requesters: round-robin issue,
// owner tags carried alongside the FPU pipe, one-hot result-valid return.
module fpu_shared_arbiter
  import fpu_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic [NUM_REQ-1:0]       Req_SI,
  input  logic [NUM_REQ*C_OP-1:0]  Operand_a_DI,
  input  logic [NUM_REQ*C_OP-1:0]  Operand_b_DI,
  input  logic [NUM_REQ*C_RM-1:0]  RM_SI,
  input  logic [NUM_REQ*C_CMD-1:0] OP_SI,
  output logic [NUM_REQ-1:0]       Gnt_SO,
  input  logic                     Stall_SI,
  output logic [NUM_REQ-1:0]       Valid_SO,
  output logic [C_OP-1:0]          Result_DO,
  output logic [C_FPU_FLAGS-1:0]   Flags_DO,
  output logic [C_OP-1:0]          Fpu_Operand_a_DO,
  output logic [C_OP-1:0]          Fpu_Operand_b_DO,
  output logic [C_RM-1:0]          Fpu_RM_SO,
  output logic [C_CMD-1:0]         Fpu_OP_SO,
  output logic                     Fpu_Enable_SO,
  output logic                     Fpu_Stall_SO,
  input  logic [C_OP-1:0]          Fpu_Result_DI,
  input  logic [C_FPU_FLAGS-1:0]   Fpu_Flags_DI
);

  fpu_req_t [NUM_REQ-1:0] req_d;
  fpu_req_t               issue_d;
  fpu_tag_t [FPU_LAT-1:0] tag_q;
  logic [ID_W-1:0]        gnt_idx;
  fpu_tag_t               tail;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) i_arb (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .req     (Req_SI),
    .en      (~Stall_SI),
    .gnt     (Gnt_SO),
    .idx     (gnt_idx)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_d[g].op_a = Operand_a_DI[g*C_OP +: C_OP];
    assign req_d[g].op_b = Operand_b_DI[g*C_OP +: C_OP];
    assign req_d[g].rm   = RM_SI[g*C_RM +: C_RM];
    assign req_d[g].op   = OP_SI[g*C_CMD +: C_CMD];
  end

  // AND-OR mux on the one-hot grant; idle cycles feed all-zero fields
  always_comb begin
    issue_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (Gnt_SO[i]) issue_d = issue_d | req_d[i];
  end

  assign Fpu_Operand_a_DO = issue_d.op_a;
  assign Fpu_Operand_b_DO = issue_d.op_b;
  assign Fpu_RM_SO        = issue_d.rm;
  assign Fpu_OP_SO        = issue_d.op;
  assign Fpu_Enable_SO    = 1'b1;
  assign Fpu_Stall_SO     = Stall_SI;

  // Owner tags advance in lockstep with the FPU pipe and freeze with it
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      tag_q <= '0;
    end else if (!Stall_SI) begin
      tag_q[0].valid <= |Gnt_SO;
      tag_q[0].id    <= C_ID_W'(gnt_idx);
      for (int k = 1; k < FPU_LAT; k++)
        tag_q[k] <= tag_q[k-1];
    end
  end

  assign tail = tag_q[FPU_LAT-1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
    assign Valid_SO[g] = Rst_RBI & ~Stall_SI & tail.valid & (tail.id == C_ID_W'(g));
  end

  assign Result_DO = Fpu_Result_DI;
  assign Flags_DO  = Fpu_Flags_DI;

endmodule
